// File: rtl/wb_arbiter_pkg.sv
// Shared core types and the default writeback channel map.
// Imported by the writeback arbiter and its round-robin picker.
package CorePack;

   localparam int XLEN = 64;
   localparam int REG_IDX_W = 5;

   typedef logic [XLEN-1:0]      data_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam int WB_SRC_ALU = 0;
   localparam int WB_SRC_MEM = 1;
   localparam int WB_SRC_PC  = 2;
   localparam int WB_SRC_CSR = 3;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin picker: first requester at or above ptr, wrapping.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter
   import CorePack::*;
#(
   parameter  int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic         hold,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         found
);

   int          j;
   logic [W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         j    = (int'(ptr) + k) % N;
         cand = W'(j);
         if (!found && !hold && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin merge of producers into one registered
// register-file write port, with retire pulse and sticky rd conflict flag.
module wb_arbiter
   import CorePack::*;
#(
   parameter  int NUM_SRC = 4,
   parameter  int DATA_W  = 64,
   parameter  int RD_W    = 5,
   localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*RD_W-1:0]   src_rd,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic                      hold,
   output logic                      wb_valid,
   output logic                      wb_en,
   output logic [RD_W-1:0]           wb_rd,
   output logic [DATA_W-1:0]         wb_data,
   output logic [SW-1:0]             wb_src,
   output logic                      conflict,
   input  logic                      conflict_clr
);

   logic [SW-1:0]      ptr;
   logic [NUM_SRC-1:0] grant;
   logic [SW-1:0]      idx;
   logic               found;
   logic               take;
   logic               match;
   logic [RD_W-1:0]    sel_rd;
   logic [DATA_W-1:0]  sel_data;
   logic [RD_W-1:0]    rd_i;
   logic [RD_W-1:0]    rd_j;

   rr_arbiter #(.N(NUM_SRC)) u_rr (
      .req   (src_valid),
      .hold  (hold),
      .ptr   (ptr),
      .grant (grant),
      .idx   (idx),
      .found (found)
   );

   // A grant seen during reset is never taken.
   assign take      = found && !rst;
   assign src_ready = rst ? '0 : grant;

   assign sel_rd   = src_rd[int'(idx)*RD_W +: RD_W];
   assign sel_data = src_data[int'(idx)*DATA_W +: DATA_W];

   assign wb_en = wb_valid && (wb_rd != '0);

   always_comb begin
      match = 1'b0;
      rd_i  = '0;
      rd_j  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = i + 1; k < NUM_SRC; k++) begin
            rd_i = src_rd[i*RD_W +: RD_W];
            rd_j = src_rd[k*RD_W +: RD_W];
            if (src_valid[i] && src_valid[k] &&
                rd_i == rd_j && rd_i != '0)
               match = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         wb_src   <= '0;
         conflict <= 1'b0;
      end else begin
         if (take) begin
            ptr      <= (idx == SW'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
            wb_valid <= 1'b1;
            wb_rd    <= sel_rd;
            wb_data  <= sel_data;
            wb_src   <= idx;
         end else begin
            wb_valid <= 1'b0;
         end
         // New match beats a same-cycle clear.
         if (match)
            conflict <= 1'b1;
         else if (conflict_clr)
            conflict <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with an expected-writeback queue.
// Grants are checked same cycle; writebacks are popped one cycle later.
module tb_wb_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   src_valid;
   logic [19:0]  src_rd;
   logic [255:0] src_data;
   logic [3:0]   src_ready;
   logic         hold;
   logic         wb_valid;
   logic         wb_en;
   logic [4:0]   wb_rd;
   logic [63:0]  wb_data;
   logic [1:0]   wb_src;
   logic         conflict;
   logic         conflict_clr;

   logic [4:0]  rdv [4];
   logic [63:0] dv  [4];

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic [1:0]  src;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   failures;

   wb_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .src_valid    (src_valid),
      .src_rd       (src_rd),
      .src_data     (src_data),
      .src_ready    (src_ready),
      .hold         (hold),
      .wb_valid     (wb_valid),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_src       (wb_src),
      .conflict     (conflict),
      .conflict_clr (conflict_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      src_rd   = '0;
      src_data = '0;
      for (int i = 0; i < 4; i++) begin
         src_rd[i*5 +: 5]    = rdv[i];
         src_data[i*64 +: 64] = dv[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check grant now, push the expected writeback, then
   // check the registered outputs just after the edge.
   task automatic cycle(input logic [3:0] er);
      exp_t e;
      #1;
      chk("src_ready", {60'd0, src_ready}, {60'd0, er});
      for (int g = 0; g < 4; g++) begin
         if (er[g]) begin
            e.rd   = rdv[g];
            e.data = dv[g];
            e.src  = 2'(g);
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      chk("wb_valid", {63'd0, wb_valid}, {63'd0, q.size() > 0});
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
         chk("wb_data", wb_data, e.data);
         chk("wb_src", {62'd0, wb_src}, {62'd0, e.src});
         chk("wb_en", {63'd0, wb_en}, {63'd0, e.rd != 5'd0});
      end else begin
         chk("wb_en_idle", {63'd0, wb_en}, 64'd0);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      src_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
      chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_wb_src", {62'd0, wb_src}, 64'd0);
      chk("rst_conflict", {63'd0, conflict}, 64'd0);
   endtask

   task automatic chk_conf(input string tag, input logic exp);
      chk(tag, {63'd0, conflict}, {63'd0, exp});
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      hold         = 1'b0;
      conflict_clr = 1'b0;
      src_valid    = '0;
      for (int i = 0; i < 4; i++) begin
         rdv[i] = '0;
         dv[i]  = '0;
      end
      @(posedge clk);
      #1;
      chk("rst_src_ready", {60'd0, src_ready}, 64'd0);
      @(posedge clk);
      #1;
      chk_reset_vals();
      rst = 1'b0;

      // single source, immediate grant
      src_valid = 4'b0001;
      rdv[0]    = 5'd5;
      dv[0]     = 64'hDEAD;
      cycle(4'b0001);
      src_valid = '0;
      cycle(4'b0000);

      // all four valid, strict rotation from ptr=0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rdv[i] = 5'(i + 1);
         dv[i]  = 64'h1000 + 64'(i);
      end
      src_valid = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         dv[n % 4] = 64'hA000 + 64'(n);
         cycle(4'b0001 << (n % 4));
      end
      src_valid = '0;
      cycle(4'b0000);

      // x0 write retires without enabling the register file
      src_valid = 4'b0100;
      rdv[2]    = 5'd0;
      dv[2]     = 64'h1234;
      cycle(4'b0100);
      src_valid = '0;
      cycle(4'b0000);

      // hold freezes grants and ptr (ptr=3 here)
      src_valid = 4'b0010;
      rdv[1]    = 5'd9;
      dv[1]     = 64'hBEEF;
      hold      = 1'b1;
      for (int n = 0; n < 3; n++)
         cycle(4'b0000);
      hold = 1'b0;
      cycle(4'b0010);
      src_valid = '0;
      cycle(4'b0000);

      // conflict: 0 and 3 both target x7 (ptr=2)
      src_valid = 4'b1001;
      rdv[0]    = 5'd7;
      rdv[3]    = 5'd7;
      dv[0]     = 64'h70;
      dv[3]     = 64'h73;
      cycle(4'b1000);
      chk_conf("conflict_set", 1'b1);
      cycle(4'b0001);
      chk_conf("conflict_sticky", 1'b1);
      src_valid    = '0;
      conflict_clr = 1'b1;
      cycle(4'b0000);
      chk_conf("conflict_clr", 1'b0);
      conflict_clr = 1'b0;
      src_valid    = 4'b1001;
      cycle(4'b1000);
      chk_conf("conflict_reset", 1'b1);
      conflict_clr = 1'b1;
      cycle(4'b0001);
      chk_conf("conflict_set_wins", 1'b1);
      conflict_clr = 1'b0;
      src_valid    = '0;
      cycle(4'b0000);

      // reset while src 1 valid and ptr=2
      src_valid = 4'b0010;
      rdv[1]    = 5'd11;
      dv[1]     = 64'hC0DE;
      cycle(4'b0010);
      rst = 1'b1;
      cycle(4'b0000);
      chk_reset_vals();
      rst       = 1'b0;
      src_valid = 4'b1010;
      rdv[3]    = 5'd12;
      dv[3]     = 64'hF00D;
      cycle(4'b0010);
      src_valid = '0;
      cycle(4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
